// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard beside decode: stalls RAW/WAW hazards and records issued destinations.
// Latency: o_stall/o_accept are combinational from current counters; a counter loads on the accepting edge.
// Backpressure: o_stall freezes fetch/decode; i_hold freezes counters. Optional perf counters: SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int LAT_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    i_rs1,
   input  logic [IDX_W-1:0]    i_rs2,
   input  logic                i_rs1_use,
   input  logic                i_rs2_use,
   input  logic [IDX_W-1:0]    i_rd,
   input  logic                i_wb_en,
   input  logic [LAT_W-1:0]    i_lat,
   input  logic                i_issue,
   input  logic                i_flush,
   input  logic                i_hold,
   output logic                o_stall,
   output logic [NUM_REGS-1:0] o_busy,
   output logic                o_accept
`ifdef SCOREBOARD_PERF_EN
   ,
   output logic [31:0]         o_stall_cycles,
   output logic [31:0]         o_waw_cycles
`endif
);

   // Remaining cycles until each register's pending write is forwardable; x0 has no entry.
   logic [LAT_W-1:0] r_cnt [NUM_REGS-1:1];

   logic [LAT_W-1:0]    w_rs1_cnt;
   logic [LAT_W-1:0]    w_rs2_cnt;
   logic [LAT_W-1:0]    w_rd_cnt;
   logic [NUM_REGS-1:0] w_busy;
   logic                w_raw;
   logic                w_waw;
   logic                w_stall;
   logic                w_accept;

   // Look up counters for the decode operands; x0 and out-of-range indices read as zero.
   always_comb begin
      w_rs1_cnt = '0;
      w_rs2_cnt = '0;
      w_rd_cnt  = '0;
      w_busy    = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         w_busy[r] = (r_cnt[r] != '0);
         if (i_rs1 == IDX_W'(r)) w_rs1_cnt = r_cnt[r];
         if (i_rs2 == IDX_W'(r)) w_rs2_cnt = r_cnt[r];
         if (i_rd  == IDX_W'(r)) w_rd_cnt  = r_cnt[r];
      end
   end

   // Hazard decision; outputs are forced low while reset is asserted so nothing issues during reset.
   always_comb begin
      w_raw    = (i_rs1_use && (w_rs1_cnt != '0)) || (i_rs2_use && (w_rs2_cnt != '0));
      // An older write landing after a younger one to the same rd must be prevented.
      w_waw    = i_wb_en && (w_rd_cnt > i_lat);
      w_stall  = rst && i_issue && !i_flush && (w_raw || w_waw || i_hold);
      w_accept = rst && i_issue && !i_flush && !w_stall;
   end

   assign o_stall  = w_stall;
   assign o_accept = w_accept;
   assign o_busy   = w_busy;

   // Counter update: hold freezes everything, issue load beats decrement, otherwise count down to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 1; r < NUM_REGS; r++) r_cnt[r] <= '0;
      end else if (!i_hold) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_accept && i_wb_en && (i_rd == IDX_W'(r)))
               r_cnt[r] <= i_lat;
            else if (r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - 1'b1;
         end
      end
   end

`ifdef SCOREBOARD_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_waw_cycles;

   // Saturating counts of all stall cycles and of stalls caused purely by WAW ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= '0;
         r_waw_cycles   <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_stall && w_waw && !w_raw && (r_waw_cycles != 32'hFFFF_FFFF))
            r_waw_cycles <= r_waw_cycles + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_waw_cycles   = r_waw_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, multi-cycle, x0, reset, WAW, flush/hold scenarios.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed from the counter rules.
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst;
   logic [4:0]  i_rs1, i_rs2, i_rd;
   logic        i_rs1_use, i_rs2_use, i_wb_en, i_issue, i_flush, i_hold;
   logic [2:0]  i_lat;
   logic        o_stall, o_accept;
   logic [31:0] o_busy;
`ifdef SCOREBOARD_PERF_EN
   logic [31:0] o_stall_cycles, o_waw_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   hazard_scoreboard #(.NUM_REGS(32), .IDX_W(5), .LAT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_rs1     (i_rs1),
      .i_rs2     (i_rs2),
      .i_rs1_use (i_rs1_use),
      .i_rs2_use (i_rs2_use),
      .i_rd      (i_rd),
      .i_wb_en   (i_wb_en),
      .i_lat     (i_lat),
      .i_issue   (i_issue),
      .i_flush   (i_flush),
      .i_hold    (i_hold),
      .o_stall   (o_stall),
      .o_busy    (o_busy),
      .o_accept  (o_accept)
`ifdef SCOREBOARD_PERF_EN
      ,
      .o_stall_cycles (o_stall_cycles),
      .o_waw_cycles   (o_waw_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one decode slot; flush and hold default to low.
   task automatic drv(input logic iss, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wb, input logic [2:0] lat);
      i_issue = iss; i_rs1 = rs1; i_rs1_use = u1; i_rs2 = rs2; i_rs2_use = u2;
      i_rd = rd; i_wb_en = wb; i_lat = lat; i_flush = 1'b0; i_hold = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state
      @(negedge clk);
      check("rst_busy", o_busy, 32'h0);
      check("rst_stall", {31'b0, o_stall}, 32'd0);
      check("rst_accept", {31'b0, o_accept}, 32'd0);
      rst = 1'b1;
      tick();

      // Load-use: lat=1 dependant stalls exactly one cycle
      drv(1, 0, 0, 0, 0, 5, 1, 1);
      @(negedge clk);
      check("lu_acc0", {31'b0, o_accept}, 32'd1);
      check("lu_stall0", {31'b0, o_stall}, 32'd0);
      tick();
      drv(1, 5, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("lu_stall1", {31'b0, o_stall}, 32'd1);
      check("lu_acc1", {31'b0, o_accept}, 32'd0);
      check("lu_busy5", {31'b0, o_busy[5]}, 32'd1);
      tick();
      @(negedge clk);
      check("lu_stall2", {31'b0, o_stall}, 32'd0);
      check("lu_acc2", {31'b0, o_accept}, 32'd1);
      tick();

      // Multi-cycle: lat=4 dependant on rs2 stalls 4 cycles
      drv(1, 0, 0, 0, 0, 7, 1, 4);
      @(negedge clk);
      check("mc_acc", {31'b0, o_accept}, 32'd1);
      tick();
      drv(1, 0, 0, 7, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mc_stall", {31'b0, o_stall}, 32'd1);
         tick();
      end
      @(negedge clk);
      check("mc_release", {31'b0, o_accept}, 32'd1);
      tick();

      // Same with hold for 2 cycles: 6 stall cycles
      drv(1, 0, 0, 0, 0, 7, 1, 4);
      @(negedge clk);
      check("mh_acc", {31'b0, o_accept}, 32'd1);
      tick();
      drv(1, 0, 0, 7, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         i_hold = (i == 1 || i == 2);
         @(negedge clk);
         check("mh_stall", {31'b0, o_stall}, 32'd1);
         tick();
      end
      i_hold = 1'b0;
      @(negedge clk);
      check("mh_release", {31'b0, o_accept}, 32'd1);
      tick();

      // x0 destination never becomes pending
      drv(1, 0, 0, 0, 0, 0, 1, 7);
      @(negedge clk);
      check("x0_acc", {31'b0, o_accept}, 32'd1);
      tick();
      drv(1, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("x0_stall", {31'b0, o_stall}, 32'd0);
      check("x0_busy", o_busy, 32'h0);
      tick();

      // Pending source not read: no stall
      drv(1, 0, 0, 0, 0, 5, 1, 3);
      tick();
      drv(1, 5, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("nouse_stall", {31'b0, o_stall}, 32'd0);
      check("nouse_busy", o_busy, 32'h0000_0020);
      tick();

      // Async reset mid-operation with cnt[5]=3
      drv(1, 0, 0, 0, 0, 5, 1, 3);
      @(negedge clk);
      check("mr_acc", {31'b0, o_accept}, 32'd1);
      tick();
      drv(1, 5, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("mr_pre_stall", {31'b0, o_stall}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("mr_busy", o_busy, 32'h0);
      check("mr_stall", {31'b0, o_stall}, 32'd0);
      check("mr_accept", {31'b0, o_accept}, 32'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mr_post_busy", o_busy, 32'h0);
      check("mr_post_stall", {31'b0, o_stall}, 32'd0);
      check("mr_post_acc", {31'b0, o_accept}, 32'd1);
      tick();

      // lat=0: fully forwardable, no pending state
      drv(1, 0, 0, 0, 0, 8, 1, 0);
      tick();
      drv(1, 8, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("l0_stall", {31'b0, o_stall}, 32'd0);
      check("l0_busy", o_busy, 32'h0);
      tick();

      // WAW: cnt[9]=5, issue rd=9 lat=2 stalls until cnt<=2 (3 cycles)
      drv(1, 0, 0, 0, 0, 9, 1, 5);
      tick();
      drv(1, 0, 0, 0, 0, 9, 1, 2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("waw_stall", {31'b0, o_stall}, 32'd1);
         tick();
      end
      @(negedge clk);
      check("waw_acc", {31'b0, o_accept}, 32'd1);
      tick();
      // cnt[9]=2; reload to 5, then lat=6 overwrites without stalling
      drv(1, 0, 0, 0, 0, 9, 1, 5);
      @(negedge clk);
      check("waw_acc5", {31'b0, o_accept}, 32'd1);
      tick();
      drv(1, 0, 0, 0, 0, 9, 1, 6);
      @(negedge clk);
      check("waw_acc6", {31'b0, o_accept}, 32'd1);
      check("waw_nostall6", {31'b0, o_stall}, 32'd0);
      tick();
      // Counter must now be 6: a reader of x9 stalls 6 cycles
      drv(1, 9, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("waw6_stall", {31'b0, o_stall}, 32'd1);
         tick();
      end
      @(negedge clk);
      check("waw6_release", {31'b0, o_accept}, 32'd1);
      tick();

      // Flush with RAW hazard present: no stall, no accept, no load
      drv(1, 0, 0, 0, 0, 3, 1, 2);
      tick();
      drv(1, 3, 1, 0, 0, 4, 1, 5);
      i_flush = 1'b1;
      @(negedge clk);
      check("fl_stall", {31'b0, o_stall}, 32'd0);
      check("fl_acc", {31'b0, o_accept}, 32'd0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("fl_busy", o_busy, 32'h0000_0008);
      // Flush together with hold: nothing recorded, counters frozen
      drv(1, 3, 1, 0, 0, 4, 1, 5);
      i_flush = 1'b1;
      i_hold  = 1'b1;
      #1;
      check("fh_stall", {31'b0, o_stall}, 32'd0);
      check("fh_acc", {31'b0, o_accept}, 32'd0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("fh_busy", o_busy, 32'h0000_0008);
      tick();
      @(negedge clk);
      check("fh_drain", o_busy, 32'h0);

`ifdef SCOREBOARD_PERF_EN
      // Since the mid-run reset: 3 WAW stalls + 6 RAW stalls
      check("perf_stall", o_stall_cycles, 32'd9);
      check("perf_waw", o_waw_cycles, 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed load-use hazard detector. The single hard-wired 1-cycle load check becomes a per-register scoreboard that tracks in-flight writes with an arbitrary result latency (multi-cycle memory, iterative multiply, filter-sort unit). It sits beside decode: it answers "may this instruction issue now?" and records the destination of every issued instruction. Fetch and decode stall on o_stall; execute is flushed with a bubble while it is high.

Parameters:
NUM_REGS, 32, number of architectural registers (index 0 hard-wired zero)
IDX_W, 5, register index width, must satisfy 2**IDX_W >= NUM_REGS
LAT_W, 3, counter width; maximum latency is 2**LAT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_rs1  in  IDX_W  source 1 index of instruction in decode
i_rs2  in  IDX_W  source 2 index of instruction in decode
i_rs1_use  in  1  instruction reads rs1
i_rs2_use  in  1  instruction reads rs2
i_rd  in  IDX_W  destination index of instruction in decode
i_wb_en  in  1  instruction writes rd
i_lat  in  LAT_W  cycles a dependant must wait after issue (0 = fully forwardable)
i_issue  in  1  decode holds a valid instruction this cycle
i_flush  in  1  branch flush; instruction in decode is discarded
i_hold  in  1  whole back-end frozen; counters do not advance
o_stall  out  1  instruction in decode must not issue
o_busy  out  NUM_REGS  per-register pending bits (counter != 0)
o_accept  out  1  issue recorded this cycle

Behaviour:
- State: one LAT_W counter per register 1..NUM_REGS-1. Register 0 has no storage; it always reads zero.
- Reset (rst low, async): all counters 0, o_busy=0, o_stall=0, o_accept=0. Perf counter also 0 if present.
- RAW: raw = (i_rs1_use & i_rs1!=0 & cnt[i_rs1]!=0) | the same term for rs2.
- WAW: waw = i_wb_en & i_rd!=0 & cnt[i_rd] > i_lat. An older write would otherwise land after the younger one.
- o_stall = i_issue & ~i_flush & (raw | waw | i_hold). It is combinational from current state, with no added latency.
- o_accept = i_issue & ~i_flush & ~o_stall.
- Per rising edge, for each register r:
  - If i_hold: hold the value.
  - Else if o_accept & i_wb_en & i_rd==r & r!=0: load i_lat. Issue wins over decrement in the same cycle.
  - Else if cnt[r]!=0: decrement by 1.
- Latency example: a load issues with i_lat=1. A dependant in decode the next cycle stalls exactly 1 cycle. This matches the legacy load-use behaviour.
- i_lat=0 with accept: the counter stays/becomes 0 and no stall is generated. Full forwarding is assumed.
- Accepting an rd that is already pending with i_lat >= remaining overwrites the counter with i_lat.
- i_flush: no counter is loaded and o_stall=0. Counters still decrement unless i_hold.
- i_hold and i_flush together: flush wins for the recorded instruction; counters hold.
- Counters saturate at 0 and never wrap below zero. i_lat is never truncated, because widths are equal.
- An async reset mid-operation discards all pending entries immediately.

Optional Feature:
SCOREBOARD_PERF_EN
- Defined: adds output o_stall_cycles (32 bits). It increments each cycle o_stall=1, saturates at 0xFFFFFFFF and is cleared by reset. It also adds output o_waw_cycles (32 bits), which counts cycles where waw & ~raw stalled, with the same saturation and reset rules.
- Undefined: neither port nor counter exists, and the stall logic is identical.

Test Plan:
- Reset: rst low mid-stream with cnt[5]=3 -> o_busy=0 and o_stall=0 immediately, still 0 after release.
- Load-use: cycle0 accept rd=5, lat=1; cycle1 rs1=5 use=1 -> o_stall=1 in cycle1, 0 in cycle2, o_accept=1 in cycle2.
- Multi-cycle: accept rd=7, lat=4; dependant on rs2=7 from the next cycle -> stalls exactly 4 cycles. With i_hold high for 2 of those cycles -> stalls 6 cycles.
- x0 and unused sources: rd=0 lat=7 then rs1=0 use=1 -> never stalls. rs1=5 pending with use=0 -> no stall.
- WAW: cnt[9]=5, issue rd=9 lat=2 -> o_stall=1 until cnt[9]<=2, then accept and load 2. Issue rd=9 lat=6 while cnt[9]=5 -> accepted, counter=6.
- Flush and perf: i_flush with raw hazard present -> o_stall=0, o_accept=0, no load. With SCOREBOARD_PERF_EN defined, o_stall_cycles equals the total stall cycles of the previous scenarios.
